// File: rtl/apb_pkg.sv
// apb_pkg: shared bus widths and requester state encoding
package apb_pkg;
  localparam int APB_ADDR_W = 5;
  localparam int APB_DATA_W = 8;
  typedef enum logic [1:0] {IDLE = 2'b00, SETUP = 2'b01, ACCESS = 2'b10} state_t;
endpackage

// File: rtl/apb_requester_if.sv
// apb_requester_if: host command/response handshakes plus the APB requester port
interface apb_requester_if;
  import apb_pkg::*;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [APB_ADDR_W-1:0] cmd_addr;
  logic [APB_DATA_W-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [APB_DATA_W-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  busy;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [APB_ADDR_W-1:0] paddr;
  logic [APB_DATA_W-1:0] pwdata;
  logic [APB_DATA_W-1:0] prdata;
  logic                  pready;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, psel, penable, pwrite, paddr, pwdata
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, prdata, pready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_watchdog.sv
// apb_watchdog: wait-cycle counter with load and terminal count for the PREADY watchdog
module apb_watchdog #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic tc
);
  localparam int W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [W-1:0] cnt;
  // Loading 1 makes cnt equal the number of ACCESS cycles spent so far, current one included
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= W'(1);
    else if (inc && !tc) cnt <= cnt + 1'b1;
  assign tc = (TIMEOUT_CYCLES != 0) && (cnt == W'(TIMEOUT_CYCLES));
endmodule

// File: rtl/apb_requester.sv
// apb_requester: single-beat host commands to APB transfers with a PREADY watchdog
module apb_requester
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input logic            PCLK,
  input logic            PRESET,
  apb_requester_if.master bus
);
  state_t                state, state_nx;
  logic [APB_ADDR_W-1:0] paddr;
  logic                  pwrite;
  logic [APB_DATA_W-1:0] pwdata;
  logic [APB_DATA_W-1:0] rsp_rdata;
  logic                  rsp_valid, rsp_err;
  logic                  cmd_ready, accept, done, tout, tc;
  always_comb begin
    cmd_ready = (state == IDLE) && (!rsp_valid || bus.rsp_ready);
    accept    = cmd_ready && bus.cmd_valid;
    done      = (state == ACCESS) && bus.pready;
    tout      = (state == ACCESS) && !bus.pready && tc;
    state_nx  = state == IDLE  ? (accept ? SETUP : IDLE) :
                state == SETUP ? ACCESS :
                (done || tout) ? IDLE : ACCESS;
  end
  always_ff @(posedge PCLK)
    if (PRESET) begin
      state     <= IDLE;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        paddr  <= bus.cmd_addr;
        pwrite <= bus.cmd_write;
        pwdata <= bus.cmd_wdata;
      end
      if (done || tout) begin
        rsp_valid <= 1'b1;
        rsp_err   <= tout;
        rsp_rdata <= (done && !pwrite) ? bus.prdata : '0;
      end else if (rsp_valid && bus.rsp_ready) rsp_valid <= 1'b0;
    end
  apb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
    .clk (PCLK),
    .rst (PRESET),
    .load(state == SETUP),
    .inc (state == ACCESS && !bus.pready),
    .tc  (tc)
  );
  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_err   = rsp_err;
  assign bus.busy      = state != IDLE;
  assign bus.psel      = state != IDLE;
  assign bus.penable   = state == ACCESS;
  assign bus.pwrite    = pwrite;
  assign bus.paddr     = paddr;
  assign bus.pwdata    = pwdata;
endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: directed and randomized checks of apb_requester against a register-file completer
module tb_apb_requester;
  import apb_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_requester_if bus();
  apb_requester #(.TIMEOUT_CYCLES(15)) dut (.PCLK(clk), .PRESET(rst), .bus(bus));

  int tests = 0;
  int fails = 0;
  int proto_err = 0;
  logic [7:0] mem [32];
  logic [7:0] ref_mem [32];
  logic init_mem = 1'b0;
  bit   rand_mode = 1'b0;
  int   wait_n = 0;
  int   rnd_wait = 0;
  int   acc_cnt = 0;
  int   eff_wait;

  function automatic logic [7:0] dflt(input int i);
    case (i)
      24: return 8'h42;
      25: return 8'h45;
      26: return 8'h2D;
      31: return 8'h01;
      default: return 8'(i * 37 + 11);
    endcase
  endfunction

  // Completer: register file with a programmable number of wait states per transfer
  always_comb eff_wait = rand_mode ? rnd_wait : wait_n;
  assign bus.pready = bus.psel && bus.penable && (acc_cnt >= eff_wait);
  assign bus.prdata = bus.pready ? mem[bus.paddr] : 8'hEE;
  always @(posedge clk) begin
    if (init_mem) for (int i = 0; i < 32; i++) mem[i] <= dflt(i);
    else if (bus.pready && bus.pwrite) mem[bus.paddr] <= bus.pwdata;
    acc_cnt <= (bus.psel && bus.penable && !bus.pready) ? acc_cnt + 1 : 0;
    if (bus.pready) rnd_wait <= $urandom_range(0, 3);
  end

  // Protocol monitor: SETUP precedes ACCESS, request stable through ACCESS, no response while busy
  logic p_psel = 1'b0, p_pen = 1'b0, p_rdy = 1'b0, p_wr = 1'b0;
  logic [4:0] p_addr = '0;
  logic [7:0] p_wd = '0;
  always @(posedge clk) begin
    if (!rst) begin
      if (bus.penable && !(bus.psel && p_psel && (!p_pen || !p_rdy) &&
          bus.paddr == p_addr && bus.pwrite == p_wr && bus.pwdata == p_wd)) proto_err++;
      if (bus.psel && !bus.penable && p_psel && (!p_pen || !p_rdy)) proto_err++;
      if (bus.busy !== bus.psel || (bus.busy && bus.rsp_valid)) proto_err++;
    end
    p_psel <= bus.psel;
    p_pen  <= bus.penable;
    p_rdy  <= bus.pready;
    p_wr   <= bus.pwrite;
    p_addr <= bus.paddr;
    p_wd   <= bus.pwdata;
  end

  task automatic do_cmd(input bit w, input logic [4:0] a, input logic [7:0] d);
    bit ok = 1'b0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      #1;
      if (bus.cmd_ready) ok = 1'b1;
      else @(negedge clk);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL cmd_accept addr=%h: CMD_READY never seen", a);
    end
  endtask

  // Called at the negedge of cycle 1; returns the cycle in which RSP_VALID was seen
  task automatic wait_rsp(input logic [7:0] wd, output int cyc, output logic [7:0] rd,
                          output logic e, output int psel_n, output bit wd_ok);
    cyc = 1;
    psel_n = 0;
    wd_ok = 1'b1;
    while (!bus.rsp_valid && cyc < 40) begin
      if (bus.psel) begin
        psel_n++;
        if (bus.pwdata !== wd) wd_ok = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    rd = bus.rsp_rdata;
    e  = bus.rsp_err;
  endtask

  task automatic test_reset;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    init_mem = 1'b1;
    for (int i = 0; i < 32; i++) ref_mem[i] = dflt(i);
    repeat (3) @(negedge clk);
    init_mem = 1'b0;
    tests++;
    if ({bus.busy, bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err,
         bus.paddr, bus.pwdata, bus.rsp_rdata} !== 27'd0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b psel=%b pen=%b pw=%b rv=%b re=%b pa=%h pwd=%h rd=%h, want all 0",
               bus.busy, bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err,
               bus.paddr, bus.pwdata, bus.rsp_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    tests++;
    if (bus.cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready);
    end
  endtask

  task automatic test_read;
    int cyc, pn;
    logic [7:0] rd;
    logic e;
    bit ok;
    logic [4:0] addrs [2];
    addrs[0] = 5'h18;
    addrs[1] = 5'h1F;
    bus.rsp_ready = 1'b1;
    wait_n = 0;
    for (int k = 0; k < 2; k++) begin
      do_cmd(1'b0, addrs[k], 8'h00);
      wait_rsp(8'h00, cyc, rd, e, pn, ok);
      tests++;
      if (cyc != 3 || rd !== ref_mem[addrs[k]] || e !== 1'b0) begin
        fails++;
        $display("FAIL read_%h: got cycle=%0d data=%h err=%b want cycle=3 data=%h err=0",
                 addrs[k], cyc, rd, e, ref_mem[addrs[k]]);
      end
    end
  endtask

  task automatic test_write_wait;
    int cyc, pn;
    logic [7:0] rd;
    logic e;
    bit ok;
    wait_n = 2;
    do_cmd(1'b1, 5'h00, 8'h01);
    wait_rsp(8'h01, cyc, rd, e, pn, ok);
    ref_mem[0] = 8'h01;
    tests++;
    if (cyc != 5 || pn != 4 || !ok || rd !== 8'h00 || e !== 1'b0) begin
      fails++;
      $display("FAIL write_wait2: got cycle=%0d psel_cycles=%0d pwdata_stable=%b data=%h err=%b want 5 4 1 00 0",
               cyc, pn, ok, rd, e);
    end
    wait_n = 0;
    do_cmd(1'b0, 5'h00, 8'h00);
    wait_rsp(8'h00, cyc, rd, e, pn, ok);
    tests++;
    if (cyc != 3 || rd !== 8'h01 || e !== 1'b0) begin
      fails++;
      $display("FAIL write_readback: got cycle=%0d data=%h err=%b want 3 01 0", cyc, rd, e);
    end
  endtask

  task automatic test_timeout;
    int cyc, pn;
    logic [7:0] rd;
    logic e;
    bit ok;
    wait_n = 100000;
    do_cmd(1'b0, 5'h03, 8'h00);
    wait_rsp(8'h00, cyc, rd, e, pn, ok);
    tests++;
    if (cyc != 17 || e !== 1'b1 || rd !== 8'h00 || bus.psel !== 1'b0) begin
      fails++;
      $display("FAIL timeout: got cycle=%0d err=%b data=%h psel=%b want 17 1 00 0", cyc, e, rd, bus.psel);
    end
    wait_n = 14;
    do_cmd(1'b0, 5'h1F, 8'h00);
    wait_rsp(8'h00, cyc, rd, e, pn, ok);
    tests++;
    if (cyc != 17 || e !== 1'b0 || rd !== ref_mem[31]) begin
      fails++;
      $display("FAIL timeout_pready_wins: got cycle=%0d err=%b data=%h want 17 0 %h", cyc, e, rd, ref_mem[31]);
    end
    wait_n = 0;
  endtask

  task automatic test_back_to_back;
    int cyc, pn;
    logic [7:0] rd;
    logic e;
    bit ok, stall_ok;
    wait_n = 0;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    do_cmd(1'b0, 5'h19, 8'h00);
    wait_rsp(8'h00, cyc, rd, e, pn, ok);
    tests++;
    if (cyc != 3 || rd !== 8'h45 || e !== 1'b0) begin
      fails++;
      $display("FAIL b2b_first: got cycle=%0d data=%h err=%b want 3 45 0", cyc, rd, e);
    end
    stall_ok = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 5'h1A;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 8'h45) stall_ok = 1'b0;
      @(negedge clk);
    end
    tests++;
    if (!stall_ok) begin
      fails++;
      $display("FAIL b2b_hold: cmd_ready/rsp changed while response pending, want cmd_ready=0 rsp=45 held");
    end
    bus.rsp_ready = 1'b1;
    #1;
    tests++;
    if (bus.cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_release: got cmd_ready=%b want 1", bus.cmd_ready);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    wait_rsp(8'h00, cyc, rd, e, pn, ok);
    tests++;
    if (cyc != 3 || rd !== 8'h2D || e !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second: got cycle=%0d data=%h err=%b want 3 2D 0", cyc, rd, e);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, pn;
    logic [7:0] rd;
    logic e;
    bit ok, quiet;
    wait_n = 100000;
    do_cmd(1'b1, 5'h05, 8'hA5);
    @(negedge clk);
    tests++;
    if (bus.psel !== 1'b1 || bus.penable !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_access: got psel=%b penable=%b want 1 1", bus.psel, bus.penable);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_drop: got psel=%b penable=%b rsp_valid=%b want 0 0 0",
               bus.psel, bus.penable, bus.rsp_valid);
    end
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) quiet = 1'b0;
    end
    tests++;
    if (!quiet) begin
      fails++;
      $display("FAIL rst_mid_after: got cmd_ready=%b rsp_valid=%b want 1 0", bus.cmd_ready, bus.rsp_valid);
    end
    wait_n = 0;
    do_cmd(1'b0, 5'h05, 8'h00);
    wait_rsp(8'h00, cyc, rd, e, pn, ok);
    tests++;
    if (cyc != 3 || rd !== ref_mem[5] || e !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_no_write: got cycle=%0d data=%h err=%b want 3 %h 0", cyc, rd, e, ref_mem[5]);
    end
  endtask

  task automatic test_random;
    logic [7:0] q [$];
    int sent = 0, got = 0;
    bit pend = 1'b0, pw = 1'b0;
    logic [4:0] pa = '0;
    logic [7:0] pd = '0;
    rand_mode = 1'b1;
    for (int c = 0; c < 30000 && got < 1000; c++) begin
      @(negedge clk);
      bus.rsp_ready = $urandom_range(0, 3) != 0;
      if (!pend && sent < 1000 && $urandom_range(0, 2) != 0) begin
        pend = 1'b1;
        pw = 1'($urandom);
        pa = 5'($urandom);
        pd = 8'($urandom);
      end
      bus.cmd_valid = pend;
      bus.cmd_write = pw;
      bus.cmd_addr  = pa;
      bus.cmd_wdata = pd;
      #1;
      if (bus.rsp_valid && bus.rsp_ready) begin
        tests++;
        if (q.size() == 0 || bus.rsp_rdata !== q[0] || bus.rsp_err !== 1'b0) begin
          fails++;
          $display("FAIL random_rsp #%0d: got data=%h err=%b want data=%h err=0",
                   got, bus.rsp_rdata, bus.rsp_err, q.size() ? q[0] : 8'h00);
        end
        if (q.size() != 0) void'(q.pop_front());
        got++;
      end
      if (pend && bus.cmd_ready) begin
        q.push_back(pw ? 8'h00 : ref_mem[pa]);
        if (pw) ref_mem[pa] = pd;
        pend = 1'b0;
        sent++;
      end
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rand_mode = 1'b0;
    tests++;
    if (got != 1000) begin
      fails++;
      $display("FAIL random_count: got %0d responses want 1000", got);
    end
    tests++;
    if (proto_err != 0) begin
      fails++;
      $display("FAIL apb_protocol: got %0d violations want 0", proto_err);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #700000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "bench timeout");
  end
endmodule
